// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } hz_state_t;

  localparam int MD_CNT_W    = 8;
  localparam int STALL_CNT_W = 32;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_exe_bubble;
    logic id_exe_hold;
    logic md_done;
  } hz_ctrl_t;

  // A load in EXE whose destination feeds a source the ID instruction reads.
  // Writes to $zero never create a dependency.
  function automatic logic load_use(
    input logic       mem_read,
    input logic [4:0] dst,
    input logic       rs_used,
    input logic [4:0] rs,
    input logic       rt_used,
    input logic [4:0] rt
  );
    return mem_read && (dst != 5'd0) &&
           ((rs_used && (rs == dst)) || (rt_used && (rt == dst)));
  endfunction

endpackage

// File: rtl/hazard_md_timer.sv
// Load/decrement counter timing the remaining EXE cycles of a mult/div.
module hazard_md_timer
  import hazard_pkg::*;
#(
  parameter int W = MD_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller: load-use bubbles, branch flushes, mult/div EXE hold
// and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_CYCLES = 4,
  parameter int STALL_W   = STALL_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic               id_rs_used,
  input  logic               id_rt_used,
  input  logic               id_branch_taken,
  input  logic               exe_mem_read,
  input  logic [4:0]         exe_reg_rt,
  input  logic               exe_md_start,
  output logic               pc_write,
  output logic               if_id_write,
  output logic               if_id_flush,
  output logic               id_exe_bubble,
  output logic               id_exe_hold,
  output logic               md_done,
  output logic [STALL_W-1:0] stall_cycles
);

  // The first EXE cycle is spent in RUN, the last one with the counter at zero.
  localparam logic [MD_CNT_W-1:0] MD_LOAD   = MD_CNT_W'(MD_CYCLES - 2);
  localparam logic [STALL_W-1:0]  STALL_MAX = STALL_CNT_MAX[STALL_W-1:0];

  hz_state_t state;
  hz_ctrl_t  ctrl;
  logic      lu;
  logic      md_stall;
  logic      md_zero;
  logic      md_load;
  logic      md_dec;

  assign md_load = (state == RUN) && exe_md_start;
  assign md_dec  = (state == MD_BUSY);

  hazard_md_timer #(.W(MD_CNT_W)) u_md_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (md_load),
    .load_val (MD_LOAD),
    .dec      (md_dec),
    .zero     (md_zero)
  );

  assign lu       = load_use(exe_mem_read, exe_reg_rt, id_rs_used, id_rs,
                             id_rt_used, id_rt);
  assign md_stall = md_load || ((state == MD_BUSY) && !md_zero);

  // Hold beats bubble beats flush; a deferred hazard re-evaluates once the
  // blocking condition clears because its instruction is still in ID.
  always_comb begin
    ctrl = '0;
    if (rst) begin
      if (md_stall) begin
        ctrl.id_exe_hold = 1'b1;
      end else if (lu) begin
        ctrl.id_exe_bubble = 1'b1;
      end else if (id_branch_taken) begin
        ctrl.pc_write    = 1'b1;
        ctrl.if_id_write = 1'b1;
        ctrl.if_id_flush = 1'b1;
      end else begin
        ctrl.pc_write    = 1'b1;
        ctrl.if_id_write = 1'b1;
      end
      ctrl.md_done = (state == MD_BUSY) && md_zero;
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign if_id_write   = ctrl.if_id_write;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_exe_bubble = ctrl.id_exe_bubble;
  assign id_exe_hold   = ctrl.id_exe_hold;
  assign md_done       = ctrl.md_done;

  // exe_md_start is ignored in MD_BUSY: it is the same held instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (exe_md_start) state <= MD_BUSY;
        MD_BUSY: if (md_zero)      state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cycles <= '0;
    else if (!ctrl.pc_write && (stall_cycles != STALL_MAX))
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expected control vectors are queued
// at drive time and popped when the outputs settle.
module tb_pipeline_hazard_ctrl;

  // {pc_write, if_id_write, if_id_flush, id_exe_bubble, id_exe_hold, md_done}
  localparam logic [5:0] ZERO   = 6'b000000;
  localparam logic [5:0] IDLE   = 6'b110000;
  localparam logic [5:0] BUB    = 6'b000100;
  localparam logic [5:0] FLS    = 6'b111000;
  localparam logic [5:0] HLD    = 6'b000010;
  localparam logic [5:0] DON    = 6'b110001;
  localparam logic [5:0] BUBDON = 6'b000101;

  typedef struct packed {
    logic [5:0] v;
    logic       sel;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, exe_reg_rt = '0;
  logic       id_rs_used = 1'b0, id_rt_used = 1'b0, id_branch_taken = 1'b0;
  logic       exe_mem_read = 1'b0, md_start = 1'b0, md2_start = 1'b0;

  logic        pw4, iw4, fl4, bb4, hd4, dn4;
  logic [31:0] sc4;
  logic        pw2, iw2, fl2, bb2, hd2, dn2;
  logic [3:0]  sc2;

  sb_t sbq[$];
  int  n_chk = 0;
  int  n_pass = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MD_CYCLES(4), .STALL_W(32)) dut4 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_branch_taken(id_branch_taken), .exe_mem_read(exe_mem_read),
    .exe_reg_rt(exe_reg_rt), .exe_md_start(md_start),
    .pc_write(pw4), .if_id_write(iw4), .if_id_flush(fl4),
    .id_exe_bubble(bb4), .id_exe_hold(hd4), .md_done(dn4),
    .stall_cycles(sc4)
  );

  // Short mult/div and a 4-bit stall counter to reach saturation quickly.
  pipeline_hazard_ctrl #(.MD_CYCLES(2), .STALL_W(4)) dut2 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_branch_taken(id_branch_taken), .exe_mem_read(exe_mem_read),
    .exe_reg_rt(exe_reg_rt), .exe_md_start(md2_start),
    .pc_write(pw2), .if_id_write(iw2), .if_id_flush(fl2),
    .id_exe_bubble(bb2), .id_exe_hold(hd2), .md_done(dn2),
    .stall_cycles(sc2)
  );

  task automatic cmp(input string tag);
    sb_t        x;
    logic [5:0] obs;
    x   = sbq.pop_front();
    obs = x.sel ? {pw2, iw2, fl2, bb2, hd2, dn2} : {pw4, iw4, fl4, bb4, hd4, dn4};
    n_chk++;
    assert (obs === x.v) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, x.v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                      input logic rsu, input logic rtu, input logic br, input logic mr,
                      input logic [4:0] ert, input logic md, input logic md2,
                      input logic [5:0] e, input logic sel);
    @(negedge clk);
    id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
    id_branch_taken = br; exe_mem_read = mr; exe_reg_rt = ert;
    md_start = md; md2_start = md2;
    sbq.push_back('{v: e, sel: sel});
    #1 cmp(tag);
  endtask

  task automatic idle(input string tag, input logic sel);
    step(tag, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, IDLE, sel);
  endtask

  initial begin
    // Reset state
    #2;
    sbq.push_back('{v: ZERO, sel: 1'b0}); cmp("rst_out4");
    sbq.push_back('{v: ZERO, sel: 1'b1}); cmp("rst_out2");
    chk("rst_sc4", sc4, 32'd0);
    chk("rst_sc2", {28'd0, sc2}, 32'd0);
    @(negedge clk); rst = 1'b1;
    idle("first_run", 1'b0);
    chk("sc_start", sc4, 32'd0);

    // Load-use, one stall cycle
    step("lu_rs", 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, BUB, 1'b0);
    idle("lu_after", 1'b0);
    chk("sc_lu", sc4, 32'd1);
    step("lu_r0", 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, IDLE, 1'b0);
    step("lu_unused", 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, IDLE, 1'b0);
    step("lu_noload", 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, IDLE, 1'b0);
    step("lu_rt", 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, BUB, 1'b0);
    idle("lu_rt_after", 1'b0);
    chk("sc_lu_rt", sc4, 32'd2);

    // Taken branch, alone and against a load-use
    step("br_flush", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, FLS, 1'b0);
    step("br_lu", 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, BUB, 1'b0);
    idle("br_after", 1'b0);
    chk("sc_br", sc4, 32'd3);

    // Mult/div, MD_CYCLES=4
    for (int i = 0; i < 3; i++)
      step("md4_hold", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, HLD, 1'b0);
    step("md4_done", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, DON, 1'b0);
    idle("md4_after", 1'b0);
    chk("sc_md4", sc4, 32'd6);

    // Load-use and branch during a hold: hold, then bubble, then flush
    for (int i = 0; i < 3; i++)
      step("sim_hold", 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, HLD, 1'b0);
    step("sim_bub", 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, BUBDON, 1'b0);
    step("sim_flush", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, FLS, 1'b0);
    idle("sim_after", 1'b0);
    chk("sc_sim", sc4, 32'd10);

    // Mult/div, MD_CYCLES=2
    step("md2_hold", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, HLD, 1'b1);
    step("md2_done", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, DON, 1'b1);
    idle("md2_after", 1'b1);

    // Reset while md_cnt==1
    for (int i = 0; i < 3; i++)
      step("mdr_hold", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, HLD, 1'b0);
    #1 rst = 1'b0;
    #1;
    sbq.push_back('{v: ZERO, sel: 1'b0}); cmp("mdr_rst_out");
    chk("mdr_rst_sc", sc4, 32'd0);
    @(negedge clk);
    rst = 1'b1; md_start = 1'b0;
    sbq.push_back('{v: IDLE, sel: 1'b0});
    #1 cmp("mdr_release");
    for (int i = 0; i < 3; i++)
      step("mdr_rerun", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, HLD, 1'b0);
    step("mdr_done", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, DON, 1'b0);
    idle("mdr_after", 1'b0);
    chk("sc_mdr", sc4, 32'd3);

    // Saturation on the 4-bit build
    chk("sat_sc2_start", {28'd0, sc2}, 32'd0);
    for (int i = 0; i < 20; i++)
      step("sat_lu", 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, BUB, 1'b0);
    idle("sat_after", 1'b0);
    chk("sat_sc4", sc4, 32'd23);
    chk("sat_sc2", {28'd0, sc2}, 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
